// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave for every CPOL/CPHA mode, any word width and
// either bit order, with RX/TX FIFOs and overrun/underrun/frame reporting.
module spi_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ss_n,
  input  logic                        sck,
  input  logic                        mosi,
  output logic                        miso,
  output logic                        miso_oe,
  output logic                        selected,
  output logic                        frame_end,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        rx_overrun,
  output logic                        tx_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  logic [2:0] ss_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic       mosi_s;
  logic       ss_fall;
  logic       ss_rise;
  logic       sck_rise;
  logic       sck_fall;
  logic       lead_edge;
  logic       trail_edge;
  logic       samp_edge;
  logic       shft_edge;

  state_t state;
  state_t state_nx;
  logic   start;
  logic   stop;
  logic   samp;
  logic   shft;

  logic [BW-1:0] bit_cnt;
  logic          word_done;

  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_nx;
  logic [DATA_W-1:0] rx_word;
  logic              rx_pend;

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] tx_src;
  logic [DATA_W-1:0] tx_src_sh;
  logic              tx_fresh;
  logic              load;
  logic              drive;
  logic              out_bit;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wr;
  logic [PW-1:0]     tx_rd;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wr;
  logic [PW-1:0]     rx_rd;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;

  // Bring the asynchronous SPI pins into clk; third flop feeds edge detect.
  // ss flops clear to 0 so a low ss_n at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b000;
      sck_q  <= {3{CPOL}};
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n};
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign mosi_s     = mosi_q[1];
  assign ss_fall    = ss_q[2] & ~ss_q[1];
  assign ss_rise    = ~ss_q[2] & ss_q[1];
  assign sck_rise   = ~sck_q[2] & sck_q[1];
  assign sck_fall   = sck_q[2] & ~sck_q[1];
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign samp_edge  = CPHA ? trail_edge : lead_edge;
  assign shft_edge  = CPHA ? lead_edge : trail_edge;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Enter a frame on ss_n falling, leave on ss_n rising.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (ss_fall) state_nx = S_ACTIVE;
      S_ACTIVE: if (ss_rise) state_nx = S_IDLE;
    endcase
  end

  // Decode per-cycle frame events; sck edges are ignored outside a frame.
  always_comb begin
    start = 1'b0;
    stop  = 1'b0;
    samp  = 1'b0;
    shft  = 1'b0;
    unique case (state)
      S_IDLE: start = ss_fall;
      S_ACTIVE: begin
        stop = ss_rise;
        samp = ~ss_rise & samp_edge;
        shft = ~ss_rise & shft_edge;
      end
    endcase
  end

  assign selected  = (state == S_ACTIVE);
  assign miso_oe   = selected;
  assign word_done = samp & (bit_cnt == LAST_BIT);

  // Bit position within the current word.
  always_ff @(posedge clk) begin
    if (rst || start || stop) bit_cnt <= '0;
    else if (samp)            bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
  end

  assign rx_nx = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s}
                           : {mosi_s, rx_sr[DATA_W-1:1]};

  // Receive shifter; a finished word is parked for a push next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr   <= '0;
      rx_word <= '0;
      rx_pend <= 1'b0;
    end else begin
      rx_pend <= word_done;
      if (samp)      rx_sr   <= rx_nx;
      if (word_done) rx_word <= rx_nx;
    end
  end

  // CPHA=1 loads the first word at select but only drives it on the first
  // shift edge, so tx_fresh marks that no reload is needed there.
  assign load    = start
                 | (shft & (bit_cnt == '0) & (~CPHA | ~tx_fresh));
  assign drive   = shft | (start & ~CPHA);
  assign ld_word = tx_empty ? '1 : tx_mem[tx_rd[AW-1:0]];
  assign tx_src  = load ? ld_word : tx_sr;
  assign out_bit = MSB_FIRST ? tx_src[DATA_W-1] : tx_src[0];
  assign tx_src_sh = MSB_FIRST ? {tx_src[DATA_W-2:0], 1'b1}
                               : {1'b1, tx_src[DATA_W-1:1]};
  assign tx_pop  = load & ~tx_empty;

  // Transmit shifter, registered miso and underrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr       <= '1;
      miso        <= 1'b1;
      tx_fresh    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load & tx_empty;
      if (start)     tx_fresh <= 1'b1;
      else if (shft) tx_fresh <= 1'b0;
      if (drive) begin
        miso  <= out_bit;
        tx_sr <= tx_src_sh;
      end else if (load) begin
        tx_sr <= tx_src;
      end
    end
  end

  // Frame boundary pulse to the command decoder.
  always_ff @(posedge clk) begin
    if (rst) frame_end <= 1'b0;
    else     frame_end <= stop;
  end

  assign tx_full  = (tx_wr[AW] != tx_rd[AW])
                  && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & tx_ready;

  // TX FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
    end
  end

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
  end

  assign rx_full  = (rx_wr[AW] != rx_rd[AW])
                  && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_valid = ~rx_empty;
  assign rx_data  = rx_mem[rx_rd[AW-1:0]];
  assign rx_count = rx_wr - rx_rd;
  assign rx_pop   = rx_ready & rx_valid;
  assign rx_push  = rx_pend & (~rx_full | rx_pop);

  // RX FIFO pointers and overrun pulse; a same-cycle pop frees the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_pend & rx_full & ~rx_pop;
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_word;
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed frames on three configurations of the slave,
// scoreboarded RX words and MISO words, pulse counters for status outputs.
module tb_spi_slave_fifo;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sck  = 1'b0;
  logic        mosi = 1'b0;
  logic        ss0  = 1'b1;
  logic        ss1  = 1'b1;
  logic        ss2  = 1'b1;
  logic [15:0] txd  = '0;
  logic        txv  = 1'b0;
  logic        rxr  = 1'b0;
  int          sel  = 0;

  logic        miso0, oe0, sel0, fe0, txr0, rxv0, ovr0, und0;
  logic [7:0]  rxd0;
  logic [4:0]  cnt0;
  logic        miso1, oe1, sel1, fe1, txr1, rxv1, ovr1, und1;
  logic [15:0] rxd1;
  logic [4:0]  cnt1;
  logic        miso2, oe2, sel2, fe2, txr2, rxv2, ovr2, und2;
  logic [7:0]  rxd2;
  logic [2:0]  cnt2;

  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CPOL(1'b0),
                   .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .ss_n(ss0), .sck(sck), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .selected(sel0), .frame_end(fe0),
    .tx_data(txd[7:0]), .tx_valid(txv && sel == 0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rxr && sel == 0),
    .rx_count(cnt0), .rx_overrun(ovr0), .tx_underrun(und0));

  spi_slave_fifo #(.DATA_W(16), .FIFO_DEPTH(16), .CPOL(1'b1),
                   .CPHA(1'b1), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .ss_n(ss1), .sck(sck), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .selected(sel1), .frame_end(fe1),
    .tx_data(txd), .tx_valid(txv && sel == 1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(rxr && sel == 1),
    .rx_count(cnt1), .rx_overrun(ovr1), .tx_underrun(und1));

  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(1'b0),
                   .CPHA(1'b0), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .ss_n(ss2), .sck(sck), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2), .selected(sel2), .frame_end(fe2),
    .tx_data(txd[7:0]), .tx_valid(txv && sel == 2), .tx_ready(txr2),
    .rx_data(rxd2), .rx_valid(rxv2), .rx_ready(rxr && sel == 2),
    .rx_count(cnt2), .rx_overrun(ovr2), .tx_underrun(und2));

  logic        miso_s;
  logic        rxv_s;
  logic [15:0] rxd_s;

  always_comb begin
    miso_s = miso0;
    rxv_s  = rxv0;
    rxd_s  = {8'h00, rxd0};
    case (sel)
      1: begin miso_s = miso1; rxv_s = rxv1; rxd_s = rxd1; end
      2: begin miso_s = miso2; rxv_s = rxv2; rxd_s = {8'h00, rxd2}; end
      default: ;
    endcase
  end

  int fe_n[3]  = '{default: 0};
  int ovr_n[3] = '{default: 0};
  int und_n[3] = '{default: 0};

  always @(posedge clk) begin
    if (fe0)  fe_n[0]  <= fe_n[0] + 1;
    if (fe1)  fe_n[1]  <= fe_n[1] + 1;
    if (fe2)  fe_n[2]  <= fe_n[2] + 1;
    if (ovr0) ovr_n[0] <= ovr_n[0] + 1;
    if (ovr1) ovr_n[1] <= ovr_n[1] + 1;
    if (ovr2) ovr_n[2] <= ovr_n[2] + 1;
    if (und0) und_n[0] <= und_n[0] + 1;
    if (und1) und_n[1] <= und_n[1] + 1;
    if (und2) und_n[2] <= und_n[2] + 1;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cw     = 8;
  bit cpol   = 1'b0;
  bit cpha   = 1'b0;
  bit msb    = 1'b1;

  logic [15:0] exp_rx[$];
  logic [15:0] exp_mi[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic ss_set(input logic v);
    case (sel)
      0: ss0 = v;
      1: ss1 = v;
      default: ss2 = v;
    endcase
  endtask

  task automatic begin_frame();
    @(negedge clk);
    ss_set(1'b0);
    #HALF;
  endtask

  task automatic end_frame();
    #HALF;
    ss_set(1'b1);
    #(4 * HALF);
  endtask

  task automatic xfer(input logic [15:0] mo, input bit lat,
                      output logic [15:0] mi);
    int idx;
    mi = '0;
    for (int i = 0; i < cw; i++) begin
      idx  = msb ? cw - 1 - i : i;
      mosi = mo[idx];
      if (!cpha) begin
        #HALF;
        mi[idx] = miso_s;
        sck = ~cpol;
        if (lat && i == cw - 1) begin
          #30;
          check("rx_lat_3clk", 32'(rxv_s), 32'(0));
          #10;
          check("rx_lat_4clk", 32'(rxv_s), 32'(1));
          #(HALF - 40);
        end else begin
          #HALF;
        end
        sck = cpol;
      end else begin
        sck = ~cpol;
        #HALF;
        mi[idx] = miso_s;
        sck = cpol;
        #HALF;
      end
    end
  endtask

  task automatic word(input logic [15:0] mo, input bit push,
                      input bit chk_mi, input bit lat);
    logic [15:0] mi;
    logic [15:0] e;
    xfer(mo, lat, mi);
    if (push) exp_rx.push_back(mo);
    if (chk_mi) begin
      e = exp_mi.pop_front();
      check("miso_word", 32'(mi), 32'(e));
    end
  endtask

  task automatic tx_push(input logic [15:0] d, input bit sent);
    @(negedge clk);
    txd = d;
    txv = 1'b1;
    @(negedge clk);
    txv = 1'b0;
    if (sent) exp_mi.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    int k;
    k = 0;
    while (!rxv_s && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(rxv_s), 32'(1));
    e = exp_rx.pop_front();
    check({tag, "_data"}, 32'(rxd_s), 32'(e));
    rxr = 1'b1;
    @(negedge clk);
    rxr = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int          fe_b;
  int          und_b;
  int          ovr_b;
  logic [15:0] dummy;

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso0), 32'(1));
    check("rst_miso_oe", 32'(oe0), 32'(0));
    check("rst_selected", 32'(sel0), 32'(0));
    check("rst_frame_end", 32'(fe0), 32'(0));
    check("rst_tx_ready", 32'(txr0), 32'(1));
    check("rst_rx_valid", 32'(rxv0), 32'(0));
    check("rst_rx_count", 32'(cnt0), 32'(0));
    check("rst_rx_overrun", 32'(ovr0), 32'(0));
    check("rst_tx_underrun", 32'(und0), 32'(0));

    // T1: mode 0, one word each way, latency and frame_end
    sel = 0; cw = 8; cpol = 0; cpha = 0; msb = 1;
    tx_push(16'h003C, 1'b1);
    fe_b = fe_n[0];
    begin_frame();
    check("t1_selected", 32'(sel0), 32'(1));
    check("t1_miso_oe", 32'(oe0), 32'(1));
    word(16'h00A5, 1'b1, 1'b1, 1'b1);
    end_frame();
    check("t1_frame_end", 32'(fe_n[0] - fe_b), 32'(1));
    check("t1_deselected", 32'(sel0), 32'(0));
    @(negedge clk);
    pop_chk("t1_rx");
    check("t1_rx_empty", 32'(rxv0), 32'(0));

    // T2: CPOL=1 CPHA=1, 16-bit LSB-first, two back-to-back words
    sel = 1; cw = 16; cpol = 1; cpha = 1; msb = 0;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    tx_push(16'hA1C3, 1'b1);
    tx_push(16'h0F5A, 1'b1);
    und_b = und_n[1];
    begin_frame();
    word(16'h1234, 1'b1, 1'b1, 1'b0);
    word(16'hBEEF, 1'b1, 1'b1, 1'b0);
    end_frame();
    check("t2_underrun", 32'(und_n[1] - und_b), 32'(0));
    @(negedge clk);
    pop_chk("t2_rx0");
    pop_chk("t2_rx1");

    // T3: empty TX FIFO sends all-ones; mid-frame write goes next word
    sel = 0; cw = 8; cpol = 0; cpha = 0; msb = 1;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    und_b = und_n[0];
    exp_mi.push_back(16'h00FF);
    begin_frame();
    fork
      word(16'h0011, 1'b1, 1'b1, 1'b0);
      begin #(6 * HALF); tx_push(16'h00C3, 1'b1); end
    join
    fork
      word(16'h0022, 1'b1, 1'b1, 1'b0);
      begin #(6 * HALF); tx_push(16'h0081, 1'b0); end
    join
    end_frame();
    check("t3_underrun", 32'(und_n[0] - und_b), 32'(1));
    @(negedge clk);
    pop_chk("t3_rx0");
    pop_chk("t3_rx1");

    // T4: depth-4 RX FIFO, no pops, five words -> one overrun
    sel = 2;
    ovr_b = ovr_n[2];
    begin_frame();
    for (int w = 1; w <= 5; w++)
      word(16'(w), w <= 4, 1'b0, 1'b0);
    end_frame();
    check("t4_rx_count", 32'(cnt2), 32'(4));
    check("t4_overrun", 32'(ovr_n[2] - ovr_b), 32'(1));
    @(negedge clk);
    for (int w = 1; w <= 4; w++) pop_chk("t4_rx");
    check("t4_rx_empty", 32'(rxv2), 32'(0));

    // T5: partial word discarded, next full word intact
    sel = 0;
    fe_b = fe_n[0];
    begin_frame();
    cw = 5;
    xfer(16'h0015, 1'b0, dummy);
    cw = 8;
    end_frame();
    check("t5_no_push", 32'(rxv0), 32'(0));
    check("t5_rx_count", 32'(cnt0), 32'(0));
    check("t5_frame_end", 32'(fe_n[0] - fe_b), 32'(1));
    begin_frame();
    word(16'h005A, 1'b1, 1'b0, 1'b0);
    end_frame();
    @(negedge clk);
    pop_chk("t5_rx");
    check("t5_rx_empty", 32'(rxv0), 32'(0));

    // T6: reset mid-word with ss_n held low
    begin_frame();
    cw = 3;
    xfer(16'h0005, 1'b0, dummy);
    cw = 8;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_selected", 32'(sel0), 32'(0));
    check("t6_miso_oe", 32'(oe0), 32'(0));
    check("t6_miso", 32'(miso0), 32'(1));
    check("t6_rx_valid", 32'(rxv0), 32'(0));
    check("t6_rx_count", 32'(cnt0), 32'(0));
    check("t6_tx_ready", 32'(txr0), 32'(1));
    xfer(16'h00C9, 1'b0, dummy);
    #(4 * HALF);
    check("t6_still_idle", 32'(sel0), 32'(0));
    check("t6_no_rx", 32'(rxv0), 32'(0));
    end_frame();
    begin_frame();
    word(16'h0077, 1'b1, 1'b0, 1'b0);
    end_frame();
    @(negedge clk);
    pop_chk("t6_rx");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
